// File: rtl/display_pkg.sv
// Shared display geometry, scheduler FSM encoding and the signed scale helper.
// Pure declarations: no latency, no backpressure.
package display_pkg;

   localparam int TOTAL_WIDTH        = 1024;
   localparam int TOTAL_HEIGHT       = 768;
   localparam int GRID_WIDTH         = 512;
   localparam int GRID_HEIGHT        = 256;
   localparam int GRID_BOTTOM_BORDER = 256;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SNAP   = 3'd1,
      SEARCH = 3'd2,
      SCALE  = 3'd3,
      COMMIT = 3'd4
   } state_t;

   // 9-bit signed coordinate times unsigned scale, kept to 12 signed bits.
   function automatic logic signed [11:0] scale12(input logic signed [8:0] v, input logic [4:0] s);
      logic signed [11:0] v12;
      logic signed [11:0] s12;
      v12 = {{3{v[8]}}, v};
      s12 = {7'd0, s};
      return v12 * s12;
   endfunction

endpackage

// File: rtl/display_frame_scheduler_if.sv
// Bundle between the position sources / VGA drawing block and the frame scheduler.
// Master drives vsync, rover/target/orientation inputs; slave returns committed display values.
interface display_frame_scheduler_if;

   logic               vsync;
   logic signed [8:0]  rover_x;
   logic signed [8:0]  rover_y;
   logic               location_valid;
   logic [4:0]         orientation;
   logic               orientation_valid;
   logic signed [8:0]  target_x;
   logic signed [8:0]  target_y;
   logic               lock_scale;

   logic signed [11:0] disp_rover_x;
   logic signed [11:0] disp_rover_y;
   logic signed [11:0] disp_target_x;
   logic signed [11:0] disp_target_y;
   logic [4:0]         disp_orientation;
   logic               disp_oriented;
   logic [4:0]         disp_scale;
   logic               frame_update;
   logic               busy;

   modport master (
      output vsync, rover_x, rover_y, location_valid, orientation, orientation_valid,
             target_x, target_y, lock_scale,
      input  disp_rover_x, disp_rover_y, disp_target_x, disp_target_y,
             disp_orientation, disp_oriented, disp_scale, frame_update, busy
   );

   modport slave (
      input  vsync, rover_x, rover_y, location_valid, orientation, orientation_valid,
             target_x, target_y, lock_scale,
      output disp_rover_x, disp_rover_y, disp_target_x, disp_target_y,
             disp_orientation, disp_oriented, disp_scale, frame_update, busy
   );

endinterface

// File: rtl/abs_max9.sv
// Larger magnitude of two signed 9-bit values as 9-bit unsigned (|-256| = 256).
// Combinational, no backpressure.
module abs_max9 (
   input  logic signed [8:0] i_a,
   input  logic signed [8:0] i_b,
   output logic [8:0]        o_max
);

   logic [8:0] w_abs_a;
   logic [8:0] w_abs_b;

   assign w_abs_a = i_a[8] ? (~$unsigned(i_a) + 9'd1) : $unsigned(i_a);
   assign w_abs_b = i_b[8] ? (~$unsigned(i_b) + 9'd1) : $unsigned(i_b);
   assign o_max   = (w_abs_a > w_abs_b) ? w_abs_a : w_abs_b;

endmodule

// File: rtl/display_frame_scheduler.sv
// Once per frame (vsync falling edge) snapshots rover/target, finds the largest fitting scale, commits screen coords.
// Commit within MAX_SCALE+3 cycles of vsync_d falling; edges while busy are ignored, no backpressure.
module display_frame_scheduler
   import display_pkg::*;
#(
   parameter int MAX_SCALE          = 10,
   parameter int GRID_HALF_WIDTH    = display_pkg::GRID_WIDTH / 2,
   parameter int GRID_HEIGHT        = display_pkg::GRID_HEIGHT,
   parameter int GRID_BOTTOM_BORDER = display_pkg::GRID_BOTTOM_BORDER
) (
   input  logic                     vclock,
   input  logic                     reset,
   display_frame_scheduler_if.slave bus
);

   localparam logic [13:0]        LIM_X = 14'(GRID_HALF_WIDTH);
   localparam logic [13:0]        LIM_Y = 14'(GRID_HEIGHT);
   localparam logic [4:0]         S_MAX = 5'(MAX_SCALE);
   localparam logic signed [11:0] Y_OFF = 12'(GRID_BOTTOM_BORDER);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_busy;
   logic               r_vsync_d;
   logic               w_edge;
   logic               w_fits;

   logic signed [8:0]  r_pend_rx, r_pend_ry;
   logic [4:0]         r_pend_orient;
   logic               r_pend_oriented;

   logic signed [8:0]  r_snap_rx, r_snap_ry, r_snap_tx, r_snap_ty;
   logic [4:0]         r_snap_orient;
   logic               r_snap_oriented;
   logic [8:0]         r_ax, r_ay, w_ax, w_ay;
   logic [4:0]         r_s;
   logic signed [11:0] r_prod_rx, r_prod_ry, r_prod_tx, r_prod_ty;

   logic signed [11:0] r_disp_rx, r_disp_ry, r_disp_tx, r_disp_ty;
   logic [4:0]         r_disp_orient;
   logic               r_disp_oriented;
   logic [4:0]         r_disp_scale;
   logic               r_frame_update;

   abs_max9 u_abs_x (.i_a(r_pend_rx), .i_b(bus.target_x), .o_max(w_ax));
   abs_max9 u_abs_y (.i_a(r_pend_ry), .i_b(bus.target_y), .o_max(w_ay));

   assign w_edge = r_vsync_d & ~bus.vsync;
   assign w_fits = (({5'd0, r_ax} * {9'd0, r_s}) <= LIM_X) &&
                   (({5'd0, r_ay} * {9'd0, r_s}) <= LIM_Y);

   always_ff @(posedge vclock) begin
      r_vsync_d <= bus.vsync;
   end

   always_ff @(posedge vclock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = (r_state != IDLE);
      case (r_state)
         IDLE:    if (w_edge) w_state_nxt = SNAP;
         SNAP:    w_state_nxt = bus.lock_scale ? SCALE : SEARCH;
         SEARCH:  if (w_fits) w_state_nxt = SCALE;
         SCALE:   w_state_nxt = COMMIT;
         COMMIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A move without a fresh orientation makes the pending orientation stale.
   always_ff @(posedge vclock) begin
      if (reset) begin
         r_pend_rx       <= '0;
         r_pend_ry       <= '0;
         r_pend_orient   <= '0;
         r_pend_oriented <= 1'b0;
      end else begin
         if (bus.location_valid) begin
            r_pend_rx <= bus.rover_x;
            r_pend_ry <= bus.rover_y;
         end
         if (bus.orientation_valid) r_pend_orient <= bus.orientation;
         if (bus.orientation_valid)   r_pend_oriented <= 1'b1;
         else if (bus.location_valid) r_pend_oriented <= 1'b0;
      end
   end

   always_ff @(posedge vclock) begin
      if (reset) begin
         r_snap_rx       <= '0;
         r_snap_ry       <= '0;
         r_snap_tx       <= '0;
         r_snap_ty       <= '0;
         r_snap_orient   <= '0;
         r_snap_oriented <= 1'b0;
         r_ax            <= '0;
         r_ay            <= '0;
         r_s             <= 5'd1;
         r_prod_rx       <= '0;
         r_prod_ry       <= '0;
         r_prod_tx       <= '0;
         r_prod_ty       <= '0;
         r_disp_rx       <= '0;
         r_disp_ry       <= Y_OFF;
         r_disp_tx       <= '0;
         r_disp_ty       <= Y_OFF;
         r_disp_orient   <= '0;
         r_disp_oriented <= 1'b0;
         r_disp_scale    <= 5'd1;
         r_frame_update  <= 1'b0;
      end else begin
         r_frame_update <= (r_state == COMMIT);
         case (r_state)
            SNAP: begin
               r_snap_rx       <= r_pend_rx;
               r_snap_ry       <= r_pend_ry;
               r_snap_tx       <= bus.target_x;
               r_snap_ty       <= bus.target_y;
               r_snap_orient   <= r_pend_orient;
               r_snap_oriented <= r_pend_oriented;
               r_ax            <= w_ax;
               r_ay            <= w_ay;
               // A locked frame reuses the committed scale and skips the search.
               r_s             <= bus.lock_scale ? r_disp_scale : S_MAX;
            end
            SEARCH: if (!w_fits) r_s <= r_s - 5'd1;
            SCALE: begin
               r_prod_rx <= scale12(r_snap_rx, r_s);
               r_prod_ry <= scale12(r_snap_ry, r_s) + Y_OFF;
               r_prod_tx <= scale12(r_snap_tx, r_s);
               r_prod_ty <= scale12(r_snap_ty, r_s) + Y_OFF;
            end
            COMMIT: begin
               r_disp_rx       <= r_prod_rx;
               r_disp_ry       <= r_prod_ry;
               r_disp_tx       <= r_prod_tx;
               r_disp_ty       <= r_prod_ty;
               r_disp_orient   <= r_snap_orient;
               r_disp_oriented <= r_snap_oriented;
               r_disp_scale    <= r_s;
            end
            default: ;
         endcase
      end
   end

   assign bus.disp_rover_x     = r_disp_rx;
   assign bus.disp_rover_y     = r_disp_ry;
   assign bus.disp_target_x    = r_disp_tx;
   assign bus.disp_target_y    = r_disp_ty;
   assign bus.disp_orientation = r_disp_orient;
   assign bus.disp_oriented    = r_disp_oriented;
   assign bus.disp_scale       = r_disp_scale;
   assign bus.frame_update     = r_frame_update;
   assign bus.busy             = w_busy;

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Bench for display_frame_scheduler: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_display_frame_scheduler;

   localparam int MAX_SCALE = 10;

   logic vclock = 1'b0;
   logic reset  = 1'b1;

   display_frame_scheduler_if bus ();

   display_frame_scheduler #(.MAX_SCALE(MAX_SCALE)) dut (
      .vclock (vclock),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 vclock = ~vclock;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model (frame granularity) ----------------
   bit m_started = 1'b0;
   int m_vd = 1;
   int m_prx = 0, m_pry = 0, m_por = 0, m_pod = 0;
   int m_snap_next = 0, m_rem = 0;
   int m_rx, m_ry, m_tx, m_ty, m_or, m_od, m_s;
   int e_rx = 0, e_ry = 256, e_tx = 0, e_ty = 256, e_or = 0, e_od = 0, e_sc = 1, e_fu = 0, e_busy = 0;

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   always @(posedge vclock) begin : model
      int edge_seen, tx, ty, ax, ay, s, k;
      m_started = 1'b1;
      if (reset) begin
         m_prx = 0; m_pry = 0; m_por = 0; m_pod = 0;
         m_snap_next = 0; m_rem = 0;
         e_rx = 0; e_ry = 256; e_tx = 0; e_ty = 256;
         e_or = 0; e_od = 0; e_sc = 1; e_fu = 0; e_busy = 0;
      end else begin
         e_fu = 0;
         edge_seen = (m_vd != 0) && !bus.vsync;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               e_rx = m_rx; e_ry = m_ry; e_tx = m_tx; e_ty = m_ty;
               e_or = m_or; e_od = m_od; e_sc = m_s; e_fu = 1; e_busy = 0;
            end
         end else if (m_snap_next != 0) begin
            tx = $signed(bus.target_x);
            ty = $signed(bus.target_y);
            ax = (iabs(m_prx) > iabs(tx)) ? iabs(m_prx) : iabs(tx);
            ay = (iabs(m_pry) > iabs(ty)) ? iabs(m_pry) : iabs(ty);
            if (bus.lock_scale) begin
               s = e_sc; k = 0;
            end else begin
               s = 1;
               for (int c = 1; c <= MAX_SCALE; c++)
                  if (ax * c <= 256 && ay * c <= 256) s = c;
               k = MAX_SCALE - s + 1;
            end
            m_rx = m_prx * s; m_ry = m_pry * s + 256;
            m_tx = tx * s;    m_ty = ty * s + 256;
            m_or = m_por; m_od = m_pod; m_s = s;
            m_snap_next = 0;
            m_rem = k + 2;
         end else if (edge_seen != 0) begin
            m_snap_next = 1;
            e_busy = 1;
         end
         if (bus.location_valid) begin
            m_prx = $signed(bus.rover_x);
            m_pry = $signed(bus.rover_y);
            if (!bus.orientation_valid) m_pod = 0;
         end
         if (bus.orientation_valid) begin
            m_por = bus.orientation;
            m_pod = 1;
         end
      end
      m_vd = bus.vsync;
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge vclock) begin : compare
      logic [60:0] got, want;
      if (m_started) begin
         got  = {bus.disp_rover_x, bus.disp_rover_y, bus.disp_target_x, bus.disp_target_y,
                 bus.disp_orientation, bus.disp_oriented, bus.disp_scale, bus.frame_update, bus.busy};
         want = {e_rx[11:0], e_ry[11:0], e_tx[11:0], e_ty[11:0],
                 e_or[4:0], e_od[0], e_sc[4:0], e_fu[0], e_busy[0]};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL outputs @%0t: got %h required %h", $time, got, want);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(negedge vclock);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   function automatic int s12(input logic [11:0] v);
      return int'($signed(v));
   endfunction

   task automatic loc(input int x, input int y, input bit with_or, input int o);
      bus.rover_x           = 9'(x);
      bus.rover_y           = 9'(y);
      bus.orientation       = 5'(o);
      bus.location_valid    = 1'b1;
      bus.orientation_valid = with_or;
      tick();
      bus.location_valid    = 1'b0;
      bus.orientation_valid = 1'b0;
   endtask

   task automatic wait_fu(output int lat);
      lat = 0;
      while (!bus.frame_update && lat < 40) begin
         tick();
         lat++;
      end
      chk("frame_update_seen", int'(bus.frame_update), 1);
   endtask

   task automatic release_vsync();
      repeat (3) tick();
      bus.vsync = 1'b1;
      repeat (3) tick();
   endtask

   task automatic frame(output int lat);
      bus.vsync = 1'b0;
      wait_fu(lat);
      release_vsync();
   endtask

   task automatic chk_disp(input string tag, input int rx, input int ry, input int tx, input int ty, input int sc);
      chk({tag, "_rover_x"},  s12(bus.disp_rover_x),  rx);
      chk({tag, "_rover_y"},  s12(bus.disp_rover_y),  ry);
      chk({tag, "_target_x"}, s12(bus.disp_target_x), tx);
      chk({tag, "_target_y"}, s12(bus.disp_target_y), ty);
      chk({tag, "_scale"},    int'(bus.disp_scale),   sc);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      bus.vsync = 1'b1;
      bus.rover_x = '0; bus.rover_y = '0;
      bus.location_valid = 1'b0; bus.orientation_valid = 1'b0; bus.orientation = '0;
      bus.target_x = '0; bus.target_y = '0; bus.lock_scale = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      chk_disp("reset", 0, 256, 0, 256, 1);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_fu", int'(bus.frame_update), 0);
      chk("reset_oriented", int'(bus.disp_oriented), 0);
      reset = 1'b0;
      tick();

      // basic frame: scale limited by target y=40
      bus.target_x = -9'sd30; bus.target_y = 9'sd40;
      loc(10, 20, 1'b0, 0);
      frame(lat);
      chk_disp("basic", 60, 376, -180, 496, 6);
      chk("basic_oriented", int'(bus.disp_oriented), 0);
      chk("basic_latency_bound", int'(lat <= MAX_SCALE + 4), 1);

      // all zero: maximum scale
      bus.target_x = '0; bus.target_y = '0;
      loc(0, 0, 1'b0, 0);
      frame(lat);
      chk_disp("zero", 0, 256, 0, 256, 10);

      // -256 boundary plus simultaneous orientation/location pulses
      bus.target_x = -9'sd256; bus.target_y = '0;
      loc(0, 0, 1'b1, 7);
      frame(lat);
      chk_disp("edge256", 0, 256, -256, 256, 1);
      chk("edge256_oriented", int'(bus.disp_oriented), 1);
      chk("edge256_orient", int'(bus.disp_orientation), 7);

      // move arriving during SEARCH belongs to the next frame
      bus.target_x = '0; bus.target_y = '0;
      loc(10, 20, 1'b0, 0);
      bus.vsync = 1'b0;
      tick(); tick();
      chk("midsearch_busy", int'(bus.busy), 1);
      loc(50, 50, 1'b0, 0);
      wait_fu(lat);
      chk_disp("midsearch_old", 100, 456, 0, 256, 10);
      release_vsync();
      frame(lat);
      chk_disp("midsearch_new", 250, 506, 0, 256, 5);

      // lock_scale keeps the committed scale
      bus.target_x = -9'sd30; bus.target_y = 9'sd40;
      loc(10, 20, 1'b0, 0);
      frame(lat);
      loc(60, 60, 1'b0, 0);
      bus.lock_scale = 1'b1;
      frame(lat);
      chk_disp("locked", 360, 616, -180, 496, 6);
      bus.lock_scale = 1'b0;

      // reset during SEARCH aborts the frame
      loc(10, 20, 1'b0, 0);
      bus.vsync = 1'b0;
      tick(); tick();
      chk("abort_busy", int'(bus.busy), 1);
      reset = 1'b1;
      tick();
      bus.vsync = 1'b1;
      tick();
      chk_disp("abort", 0, 256, 0, 256, 1);
      chk("abort_busy_after", int'(bus.busy), 0);
      chk("abort_fu", int'(bus.frame_update), 0);
      reset = 1'b0;
      repeat (2) tick();
      frame(lat);
      chk_disp("after_abort", 0, 256, -180, 496, 6);

      // randomized traffic: pulses anywhere, vsync edges while busy, occasional lock and reset
      for (int cyc = 0; cyc < 6000; cyc++) begin
         bus.location_valid    = ($urandom_range(0, 11) == 0);
         bus.orientation_valid = ($urandom_range(0, 11) == 0);
         bus.rover_x           = 9'($urandom);
         bus.rover_y           = 9'($urandom);
         bus.orientation       = 5'($urandom);
         if ($urandom_range(0, 40) == 0) begin
            bus.target_x = 9'($urandom);
            bus.target_y = 9'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40));
         end
         if ($urandom_range(0, 150) == 0) bus.lock_scale = ~bus.lock_scale;
         if ($urandom_range(0, 8) == 0)   bus.vsync = ~bus.vsync;
         reset = ($urandom_range(0, 1999) == 0);
         tick();
      end
      bus.location_valid = 1'b0; bus.orientation_valid = 1'b0;
      reset = 1'b0; bus.vsync = 1'b1;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_frame_scheduler.md
Name: display_frame_scheduler

Overview:
- Sequences position and orientation updates into the VGA drawing path once per frame.
- Buffers asynchronous rover location/orientation pulses and the target location.
- On each vsync falling edge, takes a coherent snapshot and searches for the largest integer scale factor that keeps both objects inside the 512x256 grid.
- Commits scaled, grid-offset screen coordinates with a one-cycle frame_update pulse; replaces the fixed scale and per-pixel update logic in the drawing block.

Parameters:
- MAX_SCALE, 10: largest scale factor tried, range 1..31.
- GRID_HALF_WIDTH, 256: limit on |x|*scale.
- GRID_HEIGHT, 256: limit on |y|*scale.
- GRID_BOTTOM_BORDER, 256: y offset added to committed y coordinates.

Ports:
- vclock  in  1  65 MHz pixel clock
- reset  in  1  synchronous, active-high
- vsync  in  1  XVGA vertical sync, active low
- rover_x, rover_y  in  9 each  signed cartesian rover position from polar_to_cartesian
- location_valid  in  1  one-cycle pulse, new rover position
- orientation  in  5  rover orientation code
- orientation_valid  in  1  one-cycle pulse, new orientation
- target_x, target_y  in  9 each  signed cartesian target position, sampled continuously
- lock_scale  in  1  1 = skip search and keep the current scale
- disp_rover_x, disp_rover_y  out  12 each  signed committed rover screen position
- disp_target_x, disp_target_y  out  12 each  signed committed target screen position
- disp_orientation  out  5  committed orientation
- disp_oriented  out  1  committed orientation is valid
- disp_scale  out  5  committed scale factor
- frame_update  out  1  one-cycle pulse when new values are committed
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values: disp_rover_x=0, disp_rover_y=GRID_BOTTOM_BORDER, disp_target_x=0, disp_target_y=GRID_BOTTOM_BORDER, disp_orientation=0, disp_oriented=0, disp_scale=1, frame_update=0, busy=0, FSM=IDLE, pending registers cleared.
- Pending capture runs every cycle, in any state:
  - location_valid latches rover_x/y.
  - orientation_valid latches orientation and sets pend_oriented.
  - location_valid without orientation_valid clears pend_oriented (the orientation is stale after a move).
  - Both pulses in the same cycle: latch both values; pend_oriented=1.
- vsync_d is vsync registered once. Edge = vsync_d & ~vsync, i.e. the falling edge.
- FSM states:
  - IDLE: on edge go to SNAP.
  - SNAP, 1 cycle: copy the pending rover values, pend_oriented, orientation and the target inputs into snapshot registers. Compute ax = max(|rx|,|tx|) and ay = max(|ry|,|ty|); abs of -256 is 256, 9-bit unsigned. Set s=MAX_SCALE. If lock_scale go to SCALE, else go to SEARCH.
  - SEARCH, 1 cycle per candidate: if ax*s <= GRID_HALF_WIDTH and ay*s <= GRID_HEIGHT (14-bit unsigned products), go to SCALE with s as the result; else s <= s-1. s=1 always passes because ax,ay <= 256, so s never reaches 0.
  - SCALE, 1 cycle: compute signed 12-bit products, sign-extending the 9-bit inputs. Committed x = x*s. Committed y = y*s + GRID_BOTTOM_BORDER.
  - COMMIT, 1 cycle: update all disp_* outputs together, frame_update=1, then go to IDLE.
- Latency: edge to frame_update is at most MAX_SCALE+3 cycles after vsync_d falls. This is well inside the vsync pulse, so the outputs are stable for the whole active frame.
- With lock_scale=1, disp_scale is unchanged and the coordinates are scaled with the current value, even if out of the grid.
- Pulses during SNAP are captured into pending and used in the snapshot of the next frame, never the current one. The snapshot is not altered mid-sequence.
- An edge arriving while not IDLE is ignored.
- Reset in any state returns to IDLE with reset values; no frame_update is emitted.
- busy=1 in SNAP, SEARCH, SCALE, COMMIT.

Decomposition:
- Shared package display_pkg holds:
  - TOTAL_WIDTH=1024, TOTAL_HEIGHT=768, GRID_WIDTH=512, GRID_HEIGHT=256, GRID_BOTTOM_BORDER=256;
  - the FSM state encoding (IDLE, SNAP, SEARCH, SCALE, COMMIT, 3 bits).
- One combinational sub-module, abs_max9: two signed 9-bit values in, max absolute value out as 9-bit unsigned. Instantiated twice, for x and y.

Test Plan:
- Rover (10,20) via location_valid; target (-30,40), MAX_SCALE=10; vsync falls -> scale 6, disp_rover=(60,376), disp_target=(-180,496), disp_oriented=0, one frame_update within 13 cycles.
- All coordinates 0 -> scale 10, rover (0,256), target (0,256); SEARCH exits on its first cycle.
- Target (-256,0), rover (0,0) -> scale 1, disp_target=(-256,256); orientation_valid with code 7 plus location_valid in the same cycle -> disp_oriented=1, disp_orientation=7.
- location_valid with rover (50,50) during SEARCH -> current commit shows the old rover. The next frame shows (50*s, 50*s+256) with s=5 (target 0).
- lock_scale=1, disp_scale=6, rover (60,60) -> disp_rover=(360,616), scale stays 6.
- Reset asserted in SEARCH -> no frame_update, outputs at reset values, FSM IDLE; the next vsync edge completes normally.
